// File: rtl/ca_pkg.sv
// Shared definitions for the C/A code sequencer: FSM state encoding, epoch
// length, field widths, the tap-pair payload and the PRN -> G2 phase-select
// lookup (IS-GPS-200 table, PRN 1..32).
package ca_pkg;

  localparam int unsigned CA_CHIPS = 1023;  // chips per C/A code epoch
  localparam int unsigned IDX_W    = 10;    // chip index width
  localparam int unsigned PRN_W    = 6;     // PRN select width
  localparam int unsigned TAP_W    = 4;     // G2 tap select width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_SLEW = 2'd3
  } state_t;

  typedef struct packed {
    logic [TAP_W-1:0] t0;
    logic [TAP_W-1:0] t1;
  } tap_pair_t;

  // PRN numbers with a defined code
  function automatic logic prn_valid(input logic [PRN_W-1:0] prn);
    return (prn != '0) && (prn <= PRN_W'(32));
  endfunction

  // G2 phase-select tap pair for a PRN; zero for PRNs outside the table
  function automatic tap_pair_t g2_taps(input logic [PRN_W-1:0] prn);
    tap_pair_t tp;
    case (prn)
      6'd1:    tp = {4'd2, 4'd6};
      6'd2:    tp = {4'd3, 4'd7};
      6'd3:    tp = {4'd4, 4'd8};
      6'd4:    tp = {4'd5, 4'd9};
      6'd5:    tp = {4'd1, 4'd9};
      6'd6:    tp = {4'd2, 4'd10};
      6'd7:    tp = {4'd1, 4'd8};
      6'd8:    tp = {4'd2, 4'd9};
      6'd9:    tp = {4'd3, 4'd10};
      6'd10:   tp = {4'd2, 4'd3};
      6'd11:   tp = {4'd3, 4'd4};
      6'd12:   tp = {4'd5, 4'd6};
      6'd13:   tp = {4'd6, 4'd7};
      6'd14:   tp = {4'd7, 4'd8};
      6'd15:   tp = {4'd8, 4'd9};
      6'd16:   tp = {4'd9, 4'd10};
      6'd17:   tp = {4'd1, 4'd4};
      6'd18:   tp = {4'd2, 4'd5};
      6'd19:   tp = {4'd3, 4'd6};
      6'd20:   tp = {4'd4, 4'd7};
      6'd21:   tp = {4'd5, 4'd8};
      6'd22:   tp = {4'd6, 4'd9};
      6'd23:   tp = {4'd1, 4'd3};
      6'd24:   tp = {4'd4, 4'd6};
      6'd25:   tp = {4'd5, 4'd7};
      6'd26:   tp = {4'd6, 4'd8};
      6'd27:   tp = {4'd7, 4'd9};
      6'd28:   tp = {4'd8, 4'd10};
      6'd29:   tp = {4'd1, 4'd6};
      6'd30:   tp = {4'd2, 4'd7};
      6'd31:   tp = {4'd3, 4'd8};
      6'd32:   tp = {4'd4, 4'd9};
      default: tp = '0;
    endcase
    return tp;
  endfunction

endpackage

// File: rtl/ca_chip_counter.sv
// Chip index counter: tracks which chip the C/A generator presents.
// Ports: clk, rst (sync, active-high), clr (restart at chip 0), adv (one chip
// advance), chip_idx (registered index 0..CHIPS-1), epoch (registered pulse in
// the cycle chip_idx wraps to 0).
module ca_chip_counter
  import ca_pkg::*;
#(
  parameter int unsigned CHIPS = CA_CHIPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [IDX_W-1:0] chip_idx,
  output logic             epoch
);

  logic wrap_c;

  assign wrap_c = (chip_idx == IDX_W'(CHIPS - 1));

  // Index and epoch update together so epoch lines up with the wrapping read
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      chip_idx <= '0;
      epoch    <= 1'b0;
    end else begin
      epoch <= adv && wrap_c;
      if (adv) begin
        chip_idx <= wrap_c ? '0 : chip_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/ca_code_seq.sv
// C/A code sequencer: drives reset, advance strobe and G2 tap selects of an
// external C/A code generator, tracking chip index and epoch.
// Ports: clk, rst (sync, active-high); load/prn_sel restart a PRN;
// chip_tick advances one chip; slew_req/slew_chips advance extra chips;
// gen_rst, gen_rd, gen_t0, gen_t1 to the generator; chip_idx, epoch,
// running, slew_busy, prn_err status. All outputs registered.
// Build option: define CA_CODE_SEQ_SLEW_EN to include the code slew feature;
// without it slew_req is ignored and slew_busy is held low.
module ca_code_seq
  import ca_pkg::*;
#(
  parameter int unsigned CHIPS  = CA_CHIPS,
  parameter int unsigned SLEW_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [PRN_W-1:0]  prn_sel,
  input  logic              chip_tick,
  input  logic              slew_req,
  input  logic [SLEW_W-1:0] slew_chips,
  output logic              gen_rst,
  output logic              gen_rd,
  output logic [TAP_W-1:0]  gen_t0,
  output logic [TAP_W-1:0]  gen_t1,
  output logic [IDX_W-1:0]  chip_idx,
  output logic              epoch,
  output logic              running,
  output logic              slew_busy,
  output logic              prn_err
);

  state_t    state;
  logic      adv_c;
  logic      clr_c;
  logic      prn_ok_c;
  tap_pair_t tp_c;

`ifdef CA_CODE_SEQ_SLEW_EN
  logic [SLEW_W-1:0] remaining;
  logic [SLEW_W-1:0] rem_nxt_c;

  // Ticks arriving mid-slew are folded into the outstanding count
  assign rem_nxt_c = remaining - SLEW_W'(adv_c) + SLEW_W'(chip_tick);
`else
  logic unused_slew;

  assign unused_slew = ^{slew_req, slew_chips};
  assign slew_busy   = 1'b0;
`endif

  assign prn_ok_c = prn_valid(prn_sel);
  assign tp_c     = g2_taps(prn_sel);
  assign clr_c    = load && prn_ok_c;

  // Chip advance decision; load and reset always suppress it
  always_comb begin
    adv_c = 1'b0;
    if (!rst && !load) begin
      case (state)
        ST_RUN:  adv_c = chip_tick;
`ifdef CA_CODE_SEQ_SLEW_EN
        ST_SLEW: adv_c = (remaining != '0);
`endif
        default: adv_c = 1'b0;
      endcase
    end
  end

  ca_chip_counter #(
    .CHIPS (CHIPS)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_c),
    .adv      (adv_c),
    .chip_idx (chip_idx),
    .epoch    (epoch)
  );

  // Sequencer FSM with registered generator controls and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gen_rst   <= 1'b1;
      gen_rd    <= 1'b0;
      gen_t0    <= '0;
      gen_t1    <= '0;
      running   <= 1'b0;
      prn_err   <= 1'b0;
`ifdef CA_CODE_SEQ_SLEW_EN
      slew_busy <= 1'b0;
      remaining <= '0;
`endif
    end else begin
      gen_rst <= 1'b0;
      gen_rd  <= adv_c;
      if (load) begin
        running <= 1'b0;
`ifdef CA_CODE_SEQ_SLEW_EN
        slew_busy <= 1'b0;
        remaining <= '0;
`endif
        if (prn_ok_c) begin
          state   <= ST_INIT;
          gen_rst <= 1'b1;
          gen_t0  <= tp_c.t0;
          gen_t1  <= tp_c.t1;
          prn_err <= 1'b0;
        end else begin
          state   <= ST_IDLE;
          prn_err <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: state <= ST_IDLE;
          ST_INIT: begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
          ST_RUN: begin
`ifdef CA_CODE_SEQ_SLEW_EN
            if (slew_req) begin
              state     <= ST_SLEW;
              slew_busy <= 1'b1;
              remaining <= slew_chips;
            end
`endif
          end
`ifdef CA_CODE_SEQ_SLEW_EN
          ST_SLEW: begin
            remaining <= rem_nxt_c;
            if (rem_nxt_c == '0) begin
              state     <= ST_RUN;
              slew_busy <= 1'b0;
            end
          end
`endif
          default: begin
            state   <= ST_IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ca_code_seq.sv
// Self-checking bench for ca_code_seq: directed scenarios plus random traffic,
// compared each cycle against a chip-accounting reference model, with a
// behavioural C/A generator attached to check the produced code chips.
module tb_ca_code_seq;

  localparam int CHIPS  = 1023;
  localparam int SLEW_W = 10;
`ifdef CA_CODE_SEQ_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load = 1'b0;
  logic [5:0]        prn_sel = '0;
  logic              chip_tick = 1'b0;
  logic              slew_req = 1'b0;
  logic [SLEW_W-1:0] slew_chips = '0;
  logic              gen_rst, gen_rd, epoch, running, slew_busy, prn_err;
  logic [3:0]        gen_t0, gen_t1;
  logic [9:0]        chip_idx;

  ca_code_seq #(.CHIPS(CHIPS), .SLEW_W(SLEW_W)) dut (
    .clk(clk), .rst(rst), .load(load), .prn_sel(prn_sel),
    .chip_tick(chip_tick), .slew_req(slew_req), .slew_chips(slew_chips),
    .gen_rst(gen_rst), .gen_rd(gen_rd), .gen_t0(gen_t0), .gen_t1(gen_t1),
    .chip_idx(chip_idx), .epoch(epoch), .running(running),
    .slew_busy(slew_busy), .prn_err(prn_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // IS-GPS-200 G2 phase selects, index PRN-1
  int tap_tab [32][2] = '{
    '{2,6}, '{3,7}, '{4,8}, '{5,9}, '{1,9}, '{2,10}, '{1,8}, '{2,9},
    '{3,10}, '{2,3}, '{3,4}, '{5,6}, '{6,7}, '{7,8}, '{8,9}, '{9,10},
    '{1,4}, '{2,5}, '{3,6}, '{4,7}, '{5,8}, '{6,9}, '{1,3}, '{4,6},
    '{5,7}, '{6,8}, '{7,9}, '{8,10}, '{1,6}, '{2,7}, '{3,8}, '{4,9}};

  // Behavioural C/A generator driven by the DUT's generator controls
  bit [10:1] g1 = '1;
  bit [10:1] g2 = '1;
  int        chips[$];

  function automatic int gen_out(bit [10:1] a, bit [10:1] b, int t0, int t1);
    if (t0 < 1 || t0 > 10 || t1 < 1 || t1 > 10) return 0;
    return int'(a[10] ^ b[t0] ^ b[t1]);
  endfunction

  always @(negedge clk) begin
    if (gen_rst) begin
      g1 = '1;
      g2 = '1;
      chips.delete();
      chips.push_back(gen_out(g1, g2, int'(gen_t0), int'(gen_t1)));
    end else if (gen_rd) begin
      g1 = {g1[9:1], g1[3] ^ g1[10]};
      g2 = {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
      chips.push_back(gen_out(g1, g2, int'(gen_t0), int'(gen_t1)));
    end
  end

  function automatic int chips_word10();
    int w = 0;
    if (chips.size() < 10) return -1;
    for (int i = 0; i < 10; i++) w = (w << 1) | chips[i];
    return w;
  endfunction

  // Reference model: chip position plus chips still owed to a slew
  int m_pos = 0, m_owe = 0, m_t0 = 0, m_t1 = 0;
  bit m_act = 0, m_ini = 0, m_slw = 0, m_err = 0;
  bit e_rst = 0, e_rd = 0, e_ep = 0;

  task automatic model_step(input bit r, input bit ld, input int prn,
                            input bit tk, input bit sr, input int sc);
    bit go;
    e_rd = 0;
    e_ep = 0;
    if (r) begin
      m_act = 0; m_ini = 0; m_slw = 0; m_owe = 0; m_pos = 0;
      m_t0 = 0; m_t1 = 0; m_err = 0; e_rst = 1;
    end else begin
      e_rst = 0;
      if (ld) begin
        m_act = 0; m_slw = 0; m_owe = 0;
        if (prn >= 1 && prn <= 32) begin
          m_t0 = tap_tab[prn-1][0];
          m_t1 = tap_tab[prn-1][1];
          m_err = 0; m_ini = 1; m_pos = 0; e_rst = 1;
        end else begin
          m_err = 1; m_ini = 0;
        end
      end else if (m_ini) begin
        m_ini = 0;
        m_act = 1;
      end else if (m_act) begin
        if (m_slw) begin
          go = (m_owe > 0);
          if (go) begin
            e_rd = 1; m_pos = (m_pos + 1) % CHIPS; e_ep = (m_pos == 0);
          end
          m_owe = m_owe - int'(go) + int'(tk);
          if (m_owe == 0) m_slw = 0;
        end else begin
          if (tk) begin
            e_rd = 1; m_pos = (m_pos + 1) % CHIPS; e_ep = (m_pos == 0);
          end
          if (SLEW_EN && sr) begin
            m_slw = 1;
            m_owe = sc;
          end
        end
      end
    end
  endtask

  int rd_cnt = 0, ep_cnt = 0, ep_prev = -1, run_len = 0, max_run = 0;

  // One clock: apply inputs, advance, compare every output with the model
  task automatic cyc(input bit r, input bit ld, input int prn,
                     input bit tk, input bit sr, input int sc);
    int prev_idx;
    rst = r; load = ld; prn_sel = 6'(prn); chip_tick = tk;
    slew_req = sr; slew_chips = SLEW_W'(sc);
    prev_idx = int'(chip_idx);
    @(posedge clk);
    #1;
    model_step(r, ld, prn, tk, sr, sc);
    chk("gen_rst",   int'(gen_rst),   int'(e_rst));
    chk("gen_rd",    int'(gen_rd),    int'(e_rd));
    chk("chip_idx",  int'(chip_idx),  m_pos);
    chk("epoch",     int'(epoch),     int'(e_ep));
    chk("running",   int'(running),   int'(m_act));
    chk("slew_busy", int'(slew_busy), int'(m_slw));
    chk("prn_err",   int'(prn_err),   int'(m_err));
    chk("gen_t0",    int'(gen_t0),    m_t0);
    chk("gen_t1",    int'(gen_t1),    m_t1);
    if (gen_rd) begin
      rd_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (epoch) begin
      ep_cnt++;
      ep_prev = prev_idx;
    end
    rst = 0; load = 0; chip_tick = 0; slew_req = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, and reset overriding load/tick/slew in the same cycle
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 5, 1, 1, 3);
    chk("rst_over_load_t0", int'(gen_t0), 0);
    chk("rst_gen_rst", int'(gen_rst), 1);
    idle(2);
    chk("idle_gen_rst", int'(gen_rst), 0);

    // PRN1: first ten chips octal 1440
    cyc(0, 1, 1, 0, 0, 0);
    idle(1);
    repeat (10) begin cyc(0, 0, 0, 1, 0, 0); idle(1); end
    idle(2);
    chk("prn1_code", chips_word10(), 'o1440);

    // PRN2: taps 3/7, first ten chips octal 1620
    cyc(0, 1, 2, 0, 0, 0);
    chk("prn2_t0", int'(gen_t0), 3);
    chk("prn2_t1", int'(gen_t1), 7);
    idle(1);
    repeat (10) cyc(0, 0, 0, 1, 0, 0);
    idle(2);
    chk("prn2_code", chips_word10(), 'o1620);

    // PRN5: one full epoch of back-to-back ticks
    cyc(0, 1, 5, 0, 0, 0);
    idle(1);
    rd_cnt = 0; ep_cnt = 0; ep_prev = -1;
    repeat (CHIPS) cyc(0, 0, 0, 1, 0, 0);
    idle(2);
    chk("epoch_count", ep_cnt, 1);
    chk("epoch_prev_idx", ep_prev, CHIPS - 1);
    chk("epoch_rd_count", rd_cnt, CHIPS);
    chk("epoch_idx_after", int'(chip_idx), 0);
    chk("code_period", (chips.size() > CHIPS) ? chips[CHIPS] : -1, chips[0]);

    // Slew of 5 at chip 100 with two ticks arriving mid-slew
    cyc(0, 1, 7, 0, 0, 0);
    idle(1);
    repeat (100) cyc(0, 0, 0, 1, 0, 0);
    chk("slew_start_idx", int'(chip_idx), 100);
    rd_cnt = 0; max_run = 0; run_len = 0;
    cyc(0, 0, 0, 0, 1, 5);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    idle(12);
    chk("slew_rd_count", rd_cnt, SLEW_EN ? 7 : 2);
    chk("slew_rd_run", max_run, SLEW_EN ? 7 : 2);
    chk("slew_end_idx", int'(chip_idx), SLEW_EN ? 107 : 102);
    chk("slew_end_running", int'(running), 1);

    // Zero-chip slew: one cycle busy, no reads
    rd_cnt = 0;
    cyc(0, 0, 0, 0, 1, 0);
    chk("slew0_busy", int'(slew_busy), int'(SLEW_EN));
    idle(1);
    chk("slew0_busy_after", int'(slew_busy), 0);
    chk("slew0_rd", rd_cnt, 0);

    // Invalid PRNs set prn_err, stop reads, keep taps; valid load clears
    cyc(0, 1, 0, 0, 0, 0);
    chk("prn0_err", int'(prn_err), 1);
    chk("prn0_running", int'(running), 0);
    chk("prn0_t0_kept", int'(gen_t0), 1);
    rd_cnt = 0;
    repeat (5) cyc(0, 0, 0, 1, 0, 0);
    chk("prn0_no_rd", rd_cnt, 0);
    cyc(0, 1, 40, 0, 0, 0);
    chk("prn40_err", int'(prn_err), 1);
    cyc(0, 1, 3, 0, 0, 0);
    chk("prn3_err_clr", int'(prn_err), 0);
    chk("prn3_t1", int'(gen_t1), 8);
    idle(2);

    // Reset in the middle of a long slew with a tick present
    cyc(0, 1, 9, 0, 0, 0);
    idle(1);
    repeat (3) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 30);
    idle(2);
    cyc(1, 0, 0, 1, 0, 0);
    chk("rst_slew_rd", int'(gen_rd), 0);
    chk("rst_slew_idx", int'(chip_idx), 0);
    chk("rst_slew_busy", int'(slew_busy), 0);
    idle(2);

    // Random traffic
    cyc(0, 1, 11, 0, 0, 0);
    repeat (4000) begin
      cyc(($urandom_range(0, 999) == 0),
          ($urandom_range(0, 149) == 0),
          int'($urandom_range(0, 40)),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 39) == 0),
          int'($urandom_range(0, 25)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
